// File: rtl/mess_pkg.sv
// -----------------------------------------------------------------------------
// mess_pkg
// Shared definitions for the mess-credit transaction path. This package holds
// the action-field bit positions, the two fixed charge amounts, the balance
// width, and the controller FSM state type.
// It also provides one helper function that maps an action code to its cost.
// -----------------------------------------------------------------------------
package mess_pkg;

    localparam int BAL_W            = 8;

    // Action field layout: bit0 selects recharge (1) or deduct (0);
    // bit1 selects the larger (1) or smaller (0) cost.
    localparam int ACT_RECHARGE_BIT = 0;
    localparam int ACT_COST_SEL_BIT = 1;

    localparam logic [BAL_W-1:0] COST_HI = 8'h50;
    localparam logic [BAL_W-1:0] COST_LO = 8'h49;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    function automatic logic [BAL_W-1:0] action_cost(input logic [1:0] act);
        return act[ACT_COST_SEL_BIT] ? COST_HI : COST_LO;
    endfunction

endpackage

// File: rtl/mess_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mess_rr_arbiter
// Combinational round-robin selector. It grants the first asserted request at
// or after ptr, wrapping around past N-1 back to 0.
// Ports:
//   req        in   N      request vector
//   ptr        in   IDX_W  highest-priority index for this decision
//   grant      out  N      one-hot grant (all zero when nothing requested)
//   grant_idx  out  IDX_W  binary index of the granted requester
//   any_grant  out  1      at least one request was present
// -----------------------------------------------------------------------------
module mess_rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any_grant
);

    always_comb begin
        int k;
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        k         = 0;
        // Walk the requesters in priority order starting at ptr.
        // The first one found wins.
        for (int i = 0; i < N; i++) begin
            k = (int'(ptr) + i) % N;
            if (!any_grant && req[k]) begin
                grant[k]  = 1'b1;
                grant_idx = IDX_W'(k);
                any_grant = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mess_txn_controller.sv
// -----------------------------------------------------------------------------
// mess_txn_controller
// Transaction sequencer for the mess-credit datapath.
// Round-robin arbitration selects one kiosk request at a time. For the
// selected request, the controller:
//   1. reads the student balance,
//   2. presents it to the shared credit ALU,
//   3. decides whether to commit or reject,
//   4. writes the new balance back on commit,
//   5. returns one response.
// There is one transaction in flight: IDLE -> EXEC -> RESP -> IDLE.
//
// Optional feature: define MESS_TXN_STATS_EN to add saturating commit and
// reject counters (stat_commit / stat_reject).
//
// Ports:
//   clk, rst_n       clock (rising edge); asynchronous active-low reset
//   req_valid        per-kiosk pending request
//   req_id           per-kiosk student id (slice i = kiosk i)
//   req_action       per-kiosk action (bit0 recharge, bit1 large cost)
//   req_ready        one-hot accept pulse, only in IDLE
//   alu_balance      operand balance to the ALU (0 outside EXEC)
//   alu_action       action to the ALU (0 outside EXEC)
//   alu_new_balance  ALU result
//   alu_credit_ok    ALU sufficiency flag
//   resp_valid       response held until resp_ready
//   resp_ready       consumer accept
//   resp_src         kiosk the response belongs to
//   resp_ok          1 = committed
//   resp_balance     balance after the transaction
//                    (unchanged on reject; 0 for an out-of-range id)
//   stat_commit      committed-transaction count (only with MESS_TXN_STATS_EN)
//   stat_reject      rejected-transaction count (only with MESS_TXN_STATS_EN)
// -----------------------------------------------------------------------------
module mess_txn_controller
    import mess_pkg::*;
#(
    parameter int               NUM_REQ      = 4,
    parameter int               NUM_STUDENTS = 16,
    parameter int               ID_W         = 4,
    parameter logic [BAL_W-1:0] INIT_BALANCE = 8'd200
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*ID_W-1:0]    req_id,
    input  logic [NUM_REQ*2-1:0]       req_action,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [BAL_W-1:0]           alu_balance,
    output logic [1:0]                 alu_action,
    input  logic [BAL_W-1:0]           alu_new_balance,
    input  logic                       alu_credit_ok,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [$clog2(NUM_REQ)-1:0] resp_src,
    output logic                       resp_ok,
    output logic [BAL_W-1:0]           resp_balance
`ifdef MESS_TXN_STATS_EN
    ,
    output logic [15:0]                stat_commit,
    output logic [15:0]                stat_reject
`endif
);

    localparam int SRC_W = $clog2(NUM_REQ);

    state_t             state;
    state_t             state_next;
    logic [SRC_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] grant;
    logic [SRC_W-1:0]   grant_idx;
    logic               any_grant;

    logic [ID_W-1:0]    lat_id;
    logic [1:0]         lat_act;
    logic [SRC_W-1:0]   lat_src;

    logic [BAL_W-1:0]   bal_tbl [NUM_STUDENTS];
    logic [BAL_W-1:0]   rd_bal;
    logic               in_range;
    logic               commit;

    // The ALU result wraps modulo 256. The controller therefore detects
    // recharge overflow itself, using a 9-bit sum.
    function automatic logic recharge_overflows(input logic [BAL_W-1:0] bal,
                                                input logic [1:0]       act);
        logic [BAL_W:0] sum;
        sum = {1'b0, bal} + {1'b0, action_cost(act)};
        return sum[BAL_W];
    endfunction

    mess_rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (SRC_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    assign in_range = (32'(lat_id) < NUM_STUDENTS);
    assign rd_bal   = in_range ? bal_tbl[lat_id] : '0;
    assign commit   = in_range &&
                      (lat_act[ACT_RECHARGE_BIT] ? !recharge_overflows(rd_bal, lat_act)
                                                 : alu_credit_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        req_ready   = '0;
        alu_balance = '0;
        alu_action  = '0;
        resp_valid  = 1'b0;
        case (state)
            S_IDLE: begin
                if (any_grant) begin
                    req_ready  = grant;
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_balance = rd_bal;
                alu_action  = lat_act;
                state_next  = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Request latch, round-robin pointer, and response payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr       <= '0;
            lat_id       <= '0;
            lat_act      <= '0;
            lat_src      <= '0;
            resp_ok      <= 1'b0;
            resp_balance <= '0;
            resp_src     <= '0;
        end else begin
            if (state == S_IDLE && any_grant) begin
                lat_id  <= req_id[int'(grant_idx)*ID_W +: ID_W];
                lat_act <= req_action[int'(grant_idx)*2 +: 2];
                lat_src <= grant_idx;
                rr_ptr  <= SRC_W'((int'(grant_idx) + 1) % NUM_REQ);
            end
            if (state == S_EXEC) begin
                resp_ok      <= commit;
                resp_balance <= commit ? alu_new_balance : rd_bal;
                resp_src     <= lat_src;
            end
        end
    end

    // Balance table. Every entry is reloaded on reset, so a reset
    // mid-transaction also discards any pending update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_STUDENTS; i++) begin
                bal_tbl[i] <= INIT_BALANCE;
            end
        end else if (state == S_EXEC && commit) begin
            bal_tbl[lat_id] <= alu_new_balance;
        end
    end

`ifdef MESS_TXN_STATS_EN
    // The counters update on the EXEC->RESP edge: one count per response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_commit <= '0;
            stat_reject <= '0;
        end else if (state == S_EXEC) begin
            if (commit) begin
                if (stat_commit != 16'hFFFF) stat_commit <= stat_commit + 16'd1;
            end else begin
                if (stat_reject != 16'hFFFF) stat_reject <= stat_reject + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mess_txn_controller.sv
// -----------------------------------------------------------------------------
// tb_mess_txn_controller
// Directed and randomized checks of mess_txn_controller, using 4 kiosks and
// 10 students. The shared ALU is modelled here as a plain add/subtract.
// While force_en is set, the ALU model returns force_val with credit_ok=1.
// This lets a deduct transaction load an arbitrary balance into an entry
// through the normal commit path.
// Expected results come from a per-student balance array that applies the
// commit/reject rules directly.
// -----------------------------------------------------------------------------
module tb_mess_txn_controller;

    localparam int NUM_REQ      = 4;
    localparam int NUM_STUDENTS = 10;
    localparam int ID_W         = 4;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ*ID_W-1:0] req_id;
    logic [NUM_REQ*2-1:0]    req_action;
    logic [NUM_REQ-1:0]      req_ready;
    logic [7:0]              alu_balance;
    logic [1:0]              alu_action;
    logic [7:0]              alu_new_balance;
    logic                    alu_credit_ok;
    logic                    resp_valid;
    logic                    resp_ready;
    logic [1:0]              resp_src;
    logic                    resp_ok;
    logic [7:0]              resp_balance;
`ifdef MESS_TXN_STATS_EN
    logic [15:0]             stat_commit;
    logic [15:0]             stat_reject;
`endif

    int         vectors     = 0;
    int         miscompares = 0;
    bit         force_en    = 1'b0;
    logic [7:0] force_val   = 8'd0;
    logic [7:0] alu_cost;
    int         model_bal [NUM_STUDENTS];
    int         exp_commit;
    int         exp_reject;

    always #5 clk = ~clk;

    mess_txn_controller #(
        .NUM_REQ      (NUM_REQ),
        .NUM_STUDENTS (NUM_STUDENTS),
        .ID_W         (ID_W),
        .INIT_BALANCE (8'd200)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_id          (req_id),
        .req_action      (req_action),
        .req_ready       (req_ready),
        .alu_balance     (alu_balance),
        .alu_action      (alu_action),
        .alu_new_balance (alu_new_balance),
        .alu_credit_ok   (alu_credit_ok),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_src        (resp_src),
        .resp_ok         (resp_ok),
        .resp_balance    (resp_balance)
`ifdef MESS_TXN_STATS_EN
        ,
        .stat_commit     (stat_commit),
        .stat_reject     (stat_reject)
`endif
    );

    // Shared ALU: wraps modulo 256; credit_ok when the balance covers the cost.
    always_comb begin
        alu_cost        = alu_action[1] ? 8'h50 : 8'h49;
        alu_new_balance = alu_action[0] ? alu_balance + alu_cost : alu_balance - alu_cost;
        alu_credit_ok   = (alu_balance >= alu_cost);
        if (force_en) begin
            alu_new_balance = force_val;
            alu_credit_ok   = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NUM_STUDENTS; i++) model_bal[i] = 200;
        exp_commit = 0;
        exp_reject = 0;
    endfunction

    // One transaction applied to the reference balances.
    function automatic void model_txn(input int id, input int act, output bit ok, output int bal);
        int cost;
        cost = ((act & 2) != 0) ? 80 : 73;
        ok   = 1'b0;
        bal  = 0;
        if (id < NUM_STUDENTS) begin
            if (force_en && (act & 1) == 0) begin
                model_bal[id] = int'(force_val);
                ok = 1'b1;
            end else if ((act & 1) != 0) begin
                if (model_bal[id] + cost <= 255) begin
                    model_bal[id] += cost;
                    ok = 1'b1;
                end
            end else if (model_bal[id] >= cost) begin
                model_bal[id] -= cost;
                ok = 1'b1;
            end
            bal = model_bal[id];
        end
        if (ok) exp_commit++;
        else    exp_reject++;
    endfunction

    task automatic do_txn(input int k, input int id, input int act);
        bit got;
        bit eok;
        int ebal;
        int pre;
        @(negedge clk);
        req_valid[k]               = 1'b1;
        req_id[k*ID_W +: ID_W]     = ID_W'(id);
        req_action[k*2 +: 2]       = 2'(act);
        #1;
        got = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (req_ready[k]) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        chk("grant_seen", 32'(got), 32'd1);
        if (!got) begin
            req_valid[k] = 1'b0;
            return;
        end
        chk("ready_onehot", 32'(req_ready), 32'(1 << k));
        pre = (id < NUM_STUDENTS) ? model_bal[id] : 0;
        model_txn(id, act, eok, ebal);
        @(negedge clk);
        req_valid[k] = 1'b0;
        #1;
        chk("exec_no_resp", 32'(resp_valid), 32'd0);
        if (id < NUM_STUDENTS) chk("alu_balance", 32'(alu_balance), 32'(pre));
        chk("alu_action", 32'(alu_action), 32'(act));
        @(negedge clk);
        #1;
        chk("resp_valid", 32'(resp_valid), 32'd1);
        chk("resp_src", 32'(resp_src), 32'(k));
        chk("resp_ok", 32'(resp_ok), 32'(eok));
        if (id < NUM_STUDENTS) chk("resp_balance", 32'(resp_balance), 32'(ebal));
        @(negedge clk);
        #1;
        chk("resp_drop", 32'(resp_valid), 32'd0);
    endtask

    task automatic preload(input int k, input int id, input int val);
        force_en  = 1'b1;
        force_val = 8'(val);
        do_txn(k, id, 0);
        force_en  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   exp_g [5] = '{0, 1, 2, 3, 0};
        int   pend_src [$];
        bit   pend_ok [$];
        int   pend_bal [$];
        int   gi;
        int   es;
        int   eb;
        bit   eo;
        bit   got;
        int   rk;
        int   rid;
        int   ract;

        // ---- reset state ----
        rst_n      = 1'b0;
        req_valid  = '0;
        req_id     = '0;
        req_action = '0;
        resp_ready = 1'b1;
        model_reset();
        #12;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_ok", 32'(resp_ok), 32'd0);
        chk("rst_resp_balance", 32'(resp_balance), 32'd0);
        chk("rst_resp_src", 32'(resp_src), 32'd0);
        chk("rst_alu_balance", 32'(alu_balance), 32'd0);
        chk("rst_alu_action", 32'(alu_action), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- single deduct: 200 - 0x49 = 127 ----
        do_txn(0, 3, 0);

        // ---- insufficient credit and deduct to exactly zero ----
        preload(1, 3, 72);
        do_txn(2, 3, 0);
        preload(3, 3, 73);
        do_txn(0, 3, 0);
        do_txn(1, 3, 0);
        preload(2, 4, 80);
        do_txn(3, 4, 2);

        // ---- recharge overflow boundary ----
        do_txn(0, 5, 3);
        preload(1, 5, 175);
        do_txn(2, 5, 3);
        do_txn(3, 5, 1);
        preload(0, 5, 176);
        do_txn(1, 5, 3);
        preload(2, 6, 100);
        do_txn(3, 6, 1);

        // ---- out-of-range student id ----
        do_txn(0, 12, 0);
        do_txn(1, 15, 1);
        preload(2, 11, 5);

        // ---- randomized traffic ----
        for (int r = 0; r < 40; r++) begin
            rk   = $urandom_range(0, 3);
            rid  = $urandom_range(0, 11);
            ract = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) preload(rk, rid, $urandom_range(0, 255));
            else                           do_txn(rk, rid, ract);
        end

`ifdef MESS_TXN_STATS_EN
        chk("stat_commit", 32'(stat_commit), 32'(exp_commit));
        chk("stat_reject", 32'(stat_reject), 32'(exp_reject));
`endif

        // ---- reset while in EXEC: no response, table reinitialised ----
        force_en  = 1'b1;
        force_val = 8'd11;
        @(negedge clk);
        req_valid[1]          = 1'b1;
        req_id[1*ID_W +: ID_W] = ID_W'(2);
        req_action[1*2 +: 2]   = 2'b00;
        #1;
        got = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (req_ready[1]) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        chk("abort_grant_seen", 32'(got), 32'd1);
        @(negedge clk);
        req_valid[1] = 1'b0;
        #1;
        chk("abort_in_exec", 32'(alu_balance), 32'(model_bal[2]));
        rst_n = 1'b0;
        #1;
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        chk("abort_alu_balance", 32'(alu_balance), 32'd0);
        force_en = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            #1;
            chk("abort_no_resp", 32'(resp_valid), 32'd0);
        end
`ifdef MESS_TXN_STATS_EN
        chk("stat_commit_clr", 32'(stat_commit), 32'd0);
        chk("stat_reject_clr", 32'(stat_reject), 32'd0);
`endif

        // ---- round-robin with every kiosk requesting continuously ----
        @(negedge clk);
        for (int k = 0; k < NUM_REQ; k++) begin
            req_valid[k]            = 1'b1;
            req_id[k*ID_W +: ID_W]  = ID_W'(k);
            req_action[k*2 +: 2]    = 2'b00;
        end
        gi = 0;
        for (int c = 0; c < 60 && gi < 5; c++) begin
            #1;
            if (resp_valid) begin
                chk("arb_inflight", 32'(pend_src.size()), 32'd1);
                if (pend_src.size() > 0) begin
                    es = pend_src.pop_front();
                    eo = pend_ok.pop_front();
                    eb = pend_bal.pop_front();
                    chk("arb_resp_src", 32'(resp_src), 32'(es));
                    chk("arb_resp_ok", 32'(resp_ok), 32'(eo));
                    chk("arb_resp_balance", 32'(resp_balance), 32'(eb));
                end
            end
            if (req_ready != '0) begin
                chk("arb_grant", 32'(req_ready), 32'(1 << exp_g[gi]));
                model_txn(exp_g[gi], 0, eo, eb);
                pend_src.push_back(exp_g[gi]);
                pend_ok.push_back(eo);
                pend_bal.push_back(eb);
                gi++;
            end
            if (gi < 5) @(negedge clk);
        end
        chk("arb_all_granted", 32'(gi), 32'd5);

        // ---- response backpressure blocks further grants ----
        got = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            if (resp_valid) begin
                got = 1'b1;
                break;
            end
        end
        chk("bp_resp_seen", 32'(got), 32'd1);
        resp_ready = 1'b0;
        es = 0;
        eb = 0;
        if (pend_src.size() > 0) begin
            es = pend_src.pop_front();
            eo = pend_ok.pop_front();
            eb = pend_bal.pop_front();
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            chk("bp_no_grant", 32'(req_ready), 32'd0);
            chk("bp_hold_valid", 32'(resp_valid), 32'd1);
            chk("bp_hold_src", 32'(resp_src), 32'(es));
            chk("bp_hold_balance", 32'(resp_balance), 32'(eb));
        end
        req_valid  = '0;
        resp_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("bp_released", 32'(resp_valid), 32'd0);

        // ---- every entry reads back its post-reset value ----
        for (int id = 0; id < NUM_STUDENTS; id++) begin
            do_txn(id % NUM_REQ, id, 0);
        end

`ifdef MESS_TXN_STATS_EN
        chk("stat_commit_end", 32'(stat_commit), 32'(exp_commit));
        chk("stat_reject_end", 32'(stat_reject), 32'(exp_reject));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
